// File: rtl/divider.sv
// Divides clk into a one-cycle enable tick every DIVISOR cycles; optional start gating via DIVIDER_START_TIMER_EN.
// Latency: first tick registered DIVISOR edges after reset release (or start edge), then period DIVISOR.
// Backpressure: none; free-running tick source, consumers must sample enable each cycle.
module divider #(
    parameter int DIVISOR = 50_000_000,
    parameter int CNT_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1
) (
    input  logic clk,
    input  logic reset,
`ifdef DIVIDER_START_TIMER_EN
    input  logic startTimer,
`endif
    output logic enable
);

    generate
        if (DIVISOR < 1) begin : g_bad_divisor
            $error("divider: DIVISOR must be at least 1");
        end
        if (CNT_W < 1 || (DIVISOR > 1 && (64'(DIVISOR) - 64'd1) >= (64'd1 << CNT_W))) begin : g_bad_width
            $error("divider: CNT_W too narrow to hold DIVISOR-1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVISOR - 1);

    logic [CNT_W-1:0] count;
    logic             running;
    logic             start_req;
    logic             at_last;

`ifdef DIVIDER_START_TIMER_EN
    assign start_req = startTimer;

    // Once started, the timer stays armed until the next reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            running <= 1'b0;
        end else if (startTimer) begin
            running <= 1'b1;
        end
    end
`else
    assign start_req = 1'b0;
    assign running   = 1'b1;
`endif

    assign at_last = (count == LAST);

    // Priority: reset, then (re)start, then normal count/wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            enable <= 1'b0;
        end else if (start_req) begin
            count  <= '0;
            enable <= 1'b0;
        end else if (running) begin
            if (at_last) begin
                count  <= '0;
                enable <= 1'b1;
            end else begin
                count  <= count + CNT_W'(1);
                enable <= 1'b0;
            end
        end else begin
            count  <= '0;
            enable <= 1'b0;
        end
    end

endmodule

// File: tb/tb_divider.sv
// Directed bench for divider at DIVISOR = 10, 1 and 3; start-gating scenarios run when DIVIDER_START_TIMER_EN is defined.
module tb_divider;

    logic clk;
    logic reset;
    logic st;
    logic en10, en1, en3;
    int   n_cmp;
    int   n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DIVIDER_START_TIMER_EN
    divider #(.DIVISOR(10)) u_d10 (.clk(clk), .reset(reset), .startTimer(st), .enable(en10));
    divider #(.DIVISOR(1))  u_d1  (.clk(clk), .reset(reset), .startTimer(st), .enable(en1));
    divider #(.DIVISOR(3))  u_d3  (.clk(clk), .reset(reset), .startTimer(st), .enable(en3));
`else
    divider #(.DIVISOR(10)) u_d10 (.clk(clk), .reset(reset), .enable(en10));
    divider #(.DIVISOR(1))  u_d1  (.clk(clk), .reset(reset), .enable(en1));
    divider #(.DIVISOR(3))  u_d3  (.clk(clk), .reset(reset), .enable(en3));
`endif

    task automatic check_val(input string tag, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check all three dividers e edges after a release/start edge.
    task automatic check_all(input string phase, input int e);
        check_val($sformatf("%s d10 e%0d", phase, e), en10, (e % 10) == 0);
        check_val($sformatf("%s d1 e%0d", phase, e),  en1,  1'b1);
        check_val($sformatf("%s d3 e%0d", phase, e),  en3,  (e % 3) == 0);
    endtask

    task automatic check_idle(input string phase, input int e);
        check_val($sformatf("%s d10 e%0d", phase, e), en10, 1'b0);
        check_val($sformatf("%s d1 e%0d", phase, e),  en1,  1'b0);
        check_val($sformatf("%s d3 e%0d", phase, e),  en3,  1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        st    = 1'b0;
        tick();
        check_idle("reset", 0);
        reset = 1'b0;

`ifndef DIVIDER_START_TIMER_EN
        // Free run: ticks on edges 10/20/30, every edge, and every third edge.
        for (int e = 1; e <= 30; e++) begin
            tick();
            check_all("run", e);
        end
        // Bring d10 to count 6, then reset mid-count.
        for (int e = 1; e <= 6; e++) begin
            tick();
            check_val($sformatf("pre d10 e%0d", e), en10, 1'b0);
        end
        reset = 1'b1;
        tick();
        check_idle("midrst", 0);
        reset = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            check_all("after", e);
        end
`else
        // Idle after reset until a start arrives.
        for (int e = 1; e <= 50; e++) begin
            tick();
            check_idle("idle", e);
        end
        st = 1'b1;
        tick();
        check_idle("start", 0);
        st = 1'b0;
        for (int e = 1; e <= 19; e++) begin
            tick();
            check_all("run", e);
        end
        // d10 now sits at count 9; a restart must suppress the pending tick.
        st = 1'b1;
        tick();
        check_idle("restart", 0);
        st = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            check_all("rerun", e);
        end
        // Reset wins over a simultaneous start.
        reset = 1'b1;
        st    = 1'b1;
        tick();
        check_idle("rst_st", 0);
        reset = 1'b0;
        st    = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            check_idle("postrst", e);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 The module SHALL have parameter DIVISOR, default 50_000_000, meaning clock cycles per enable pulse (1 Hz tick from 50 MHz).
REQ-002 The module SHALL have parameter CNT_W, default $clog2(DIVISOR) (minimum 1), meaning counter width in bits.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all logic is clocked on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-005 The module SHALL have port startTimer, input, 1 bit, a synchronous restart request; the port exists only when START_TIMER_EN is defined.
REQ-006 The module SHALL have port enable, output, 1 bit, a registered single-cycle tick.

Function
REQ-007 The module SHALL hold an internal counter, count, of CNT_W bits, ranging 0..DIVISOR-1.
REQ-008 When running and count != DIVISOR-1, each rising edge SHALL increment count by 1 and drive enable low.
REQ-009 When running and count == DIVISOR-1, the rising edge SHALL wrap count to 0 and drive enable high for exactly one cycle.
REQ-010 enable SHALL be registered, with no combinational path from any input to enable.
REQ-011 Timing: the first enable SHALL be high in the cycle after the DIVISOR-th rising edge following release of reset (or of a start).
REQ-012 Timing: enable period SHALL then be exactly DIVISOR cycles, with a duty of 1 cycle.
REQ-013 For DIVISOR == 1, enable SHALL be high every cycle after the first edge following reset.
REQ-014 DIVISOR < 1 SHALL be rejected at elaboration (generate-time error).
REQ-015 The counter SHALL never exceed DIVISOR-1, including when DIVISOR is not a power of two.

Reset
REQ-016 While reset is high at a rising edge, count SHALL become 0 and enable SHALL become 0.
REQ-017 Reset asserted mid-count SHALL discard the partial count.
REQ-018 After reset is released, the next full DIVISOR-cycle interval SHALL begin from count 0.
REQ-019 reset SHALL take priority over startTimer and over wrap.
REQ-020 When START_TIMER_EN is defined, reset SHALL also clear the internal running flag.

Configuration
REQ-021 The feature SHALL be controlled by macro DIVIDER_START_TIMER_EN.
REQ-022 With DIVIDER_START_TIMER_EN undefined, there SHALL be no startTimer port and the counter SHALL free-run; it is always running after reset.
REQ-023 With the macro defined, after reset the counter SHALL be idle: count held at 0 and enable held at 0.
REQ-024 With the macro defined, startTimer high at a rising edge (reset low) SHALL set running, force count to 0 and force enable to 0.
REQ-025 With the macro defined, startTimer high while already running SHALL restart the count from 0, with no enable that cycle even if count was DIVISOR-1.
REQ-026 With the macro defined, the first enable after a start SHALL occur DIVISOR edges after the start edge.
REQ-027 With the macro defined, running SHALL remain set until reset.

Verification
REQ-028 DIVISOR=10, macro off: reset high 1 cycle, then low -> enable high on edges 10, 20, 30 after release, low otherwise.
REQ-029 DIVISOR=10: assert reset for 1 cycle when count=6 -> enable stays 0, next enable 10 edges after reset release.
REQ-030 DIVISOR=1: release reset -> enable high every cycle; DIVISOR=3 -> enable pattern 0,0,1 repeating (non-power-of-two wrap).
REQ-031 DIVISOR=10, macro on: release reset, no start for 50 cycles -> enable stays 0; pulse startTimer 1 cycle -> first enable 10 edges later.
REQ-032 DIVISOR=10, macro on, running: pulse startTimer when count=9 -> no enable that cycle, next enable 10 edges after the start edge.
REQ-033 DIVISOR=10, macro on: reset and startTimer high on the same edge -> idle (enable 0 for next 20 cycles).
